// File: rtl/fd_multiciclo.sv
// fd_multiciclo: multi-cycle RISC-V integer-subset datapath with its own stage sequencer.
// Defining FD_MC_MUL_EN adds an iterative shift-add mul; otherwise that encoding halts.
module fd_multiciclo #(
  parameter int xlen     = 64,
  parameter int i_addr_w = 6,
  parameter int d_addr_w = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [i_addr_w-1:0] i_mem_addr,
  output logic                i_mem_req,
  input  logic                i_mem_ack,
  input  logic [31:0]         i_mem_data,
  output logic [d_addr_w-1:0] d_mem_addr,
  output logic                d_mem_req,
  output logic                d_mem_we,
  output logic [xlen-1:0]     d_mem_wdata,
  input  logic [xlen-1:0]     d_mem_rdata,
  input  logic                d_mem_ack,
  output logic                retire,
  output logic                halt
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI,
    OP_LD, OP_SD, OP_BEQ, OP_BNE, OP_JAL, OP_MUL
  } op_t;

  localparam logic [2:0]      LS_F3 = (xlen == 64) ? 3'b011 : 3'b010;
  localparam logic [xlen-1:0] FOUR  = 4;

  state_t                  state_q;
  op_t                     op_q, op_d;
  logic [xlen-1:0]         pc_q;
  logic [31:0]             ir_q;
  logic signed [xlen-1:0]  a_q, b_q, imm_q, imm_d;
  logic [xlen-1:0]         alu_q, alu_d, mdr_q;
  logic                    taken_q, taken_d, legal_d;
  logic                    i_req_q, d_req_q, d_we_q, retire_q, halt_q;
  logic [xlen-1:0]         regs_q [32];
  logic [xlen-1:0]         imm_i, imm_s, imm_b, imm_j;
`ifdef FD_MC_MUL_EN
  localparam int MCNT_W = $clog2(xlen);
  logic [MCNT_W-1:0]       mcnt_q;
`endif

  assign imm_i = {{(xlen-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(xlen-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{(xlen-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{(xlen-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // Decode: operation class, legality and immediate from IR
  always_comb begin
    op_d    = OP_ADD;
    legal_d = 1'b1;
    imm_d   = '0;
    case (ir_q[6:0])
      7'b0110011: begin
        case ({ir_q[31:25], ir_q[14:12]})
          10'b0000000_000: op_d = OP_ADD;
          10'b0100000_000: op_d = OP_SUB;
          10'b0000000_111: op_d = OP_AND;
          10'b0000000_110: op_d = OP_OR;
          10'b0000000_100: op_d = OP_XOR;
          10'b0000000_010: op_d = OP_SLT;
`ifdef FD_MC_MUL_EN
          10'b0000001_000: op_d = OP_MUL;
`endif
          default:         legal_d = 1'b0;
        endcase
      end
      7'b0010011: begin op_d = OP_ADDI; imm_d = imm_i; legal_d = (ir_q[14:12] == 3'b000); end
      7'b0000011: begin op_d = OP_LD;   imm_d = imm_i; legal_d = (ir_q[14:12] == LS_F3); end
      7'b0100011: begin op_d = OP_SD;   imm_d = imm_s; legal_d = (ir_q[14:12] == LS_F3); end
      7'b1100011: begin
        imm_d = imm_b;
        case (ir_q[14:12])
          3'b000:  op_d = OP_BEQ;
          3'b001:  op_d = OP_BNE;
          default: legal_d = 1'b0;
        endcase
      end
      7'b1101111: begin op_d = OP_JAL; imm_d = imm_j; end
      default:    legal_d = 1'b0;
    endcase
  end

  always_comb begin
    alu_d = '0;
    case (op_q)
      OP_ADD:               alu_d = a_q + b_q;
      OP_SUB:               alu_d = a_q - b_q;
      OP_AND:               alu_d = a_q & b_q;
      OP_OR:                alu_d = a_q | b_q;
      OP_XOR:               alu_d = a_q ^ b_q;
      OP_SLT:               alu_d = {{(xlen-1){1'b0}}, (a_q < b_q)};
      OP_ADDI, OP_LD, OP_SD: alu_d = a_q + imm_q;
      OP_JAL:               alu_d = pc_q + FOUR;
      default:              alu_d = '0;
    endcase
    taken_d = ((op_q == OP_BEQ) && (a_q == b_q)) || ((op_q == OP_BNE) && (a_q != b_q));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      i_req_q  <= 1'b0;
      d_req_q  <= 1'b0;
      d_we_q   <= 1'b0;
      retire_q <= 1'b0;
      halt_q   <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (i_req_q && i_mem_ack) begin
            ir_q    <= i_mem_data;
            i_req_q <= 1'b0;
            state_q <= S_DECODE;
          end else begin
            i_req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          a_q   <= regs_q[ir_q[19:15]];
          b_q   <= regs_q[ir_q[24:20]];
          imm_q <= imm_d;
          op_q  <= op_d;
          alu_q <= '0;
`ifdef FD_MC_MUL_EN
          mcnt_q <= '0;
`endif
          if (legal_d) begin
            state_q <= S_EXEC;
          end else begin
            state_q <= S_HALT;
            halt_q  <= 1'b1;
          end
        end
        S_EXEC: begin
          taken_q <= taken_d;
          if (op_q == OP_MUL) begin
`ifdef FD_MC_MUL_EN
            // One multiplier bit per cycle; ALUOut doubles as the accumulator
            alu_q  <= b_q[0] ? alu_q + $unsigned(a_q) : alu_q;
            a_q    <= a_q <<< 1;
            b_q    <= b_q >> 1;
            mcnt_q <= mcnt_q + 1'b1;
            if (mcnt_q == MCNT_W'(xlen - 1)) begin
              state_q  <= S_WB;
              retire_q <= 1'b1;
            end
`endif
          end else begin
            alu_q <= alu_d;
            if (op_q == OP_LD || op_q == OP_SD) begin
              state_q <= S_MEM;
              d_req_q <= 1'b1;
              d_we_q  <= (op_q == OP_SD);
            end else begin
              state_q  <= S_WB;
              retire_q <= 1'b1;
            end
          end
        end
        S_MEM: begin
          if (d_req_q && d_mem_ack) begin
            if (op_q == OP_LD) mdr_q <= d_mem_rdata;
            d_req_q  <= 1'b0;
            d_we_q   <= 1'b0;
            state_q  <= S_WB;
            retire_q <= 1'b1;
          end
        end
        S_WB: begin
          if (op_q != OP_SD && op_q != OP_BEQ && op_q != OP_BNE && ir_q[11:7] != 5'd0)
            regs_q[ir_q[11:7]] <= (op_q == OP_LD) ? mdr_q : alu_q;
          pc_q    <= (op_q == OP_JAL || taken_q) ? pc_q + $unsigned(imm_q) : pc_q + FOUR;
          i_req_q <= 1'b1;
          state_q <= S_FETCH;
        end
        S_HALT: begin
          i_req_q <= 1'b0;
          d_req_q <= 1'b0;
          d_we_q  <= 1'b0;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign i_mem_addr  = pc_q[i_addr_w-1:0];
  assign i_mem_req   = i_req_q;
  assign d_mem_addr  = alu_q[d_addr_w-1:0];
  assign d_mem_req   = d_req_q;
  assign d_mem_we    = d_we_q;
  assign d_mem_wdata = b_q;
  assign retire      = retire_q;
  assign halt        = halt_q;
endmodule

// File: tb/tb_fd_multiciclo.sv
// Directed bench for fd_multiciclo: memory models with programmable wait states,
// fetch-PC and store scoreboards, retire-latency and halt checks.
module tb_fd_multiciclo;
  logic        clk, rst_n;
  logic [7:0]  i_mem_addr;
  logic        i_mem_req, i_mem_ack;
  logic [31:0] i_mem_data;
  logic [5:0]  d_mem_addr;
  logic        d_mem_req, d_mem_we, d_mem_ack;
  logic [63:0] d_mem_wdata, d_mem_rdata;
  logic        retire, halt;

  fd_multiciclo #(.xlen(64), .i_addr_w(8), .d_addr_w(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_addr(i_mem_addr), .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .d_mem_addr(d_mem_addr), .d_mem_req(d_mem_req), .d_mem_we(d_mem_we), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ack(d_mem_ack), .retire(retire), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] addr; logic [63:0] data; } st_t;
  st_t        exp_st[$];
  logic [7:0] exp_fetch[$];
  int vectors = 0, miscompares = 0;

  logic [31:0] imem [64];
  logic [63:0] dmem [8];
  int i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0, d_len = 0;
  logic i_ack_force = 1'b0;

  assign i_mem_ack   = (i_mem_req && (i_cnt >= i_wait)) || i_ack_force;
  assign d_mem_ack   = d_mem_req && (d_cnt >= d_wait);
  assign i_mem_data  = imem[i_mem_addr[7:2]];
  assign d_mem_rdata = dmem[d_mem_addr[5:3]];

  always @(posedge clk) begin
    i_cnt <= (i_mem_req && !i_mem_ack) ? i_cnt + 1 : 0;
    d_cnt <= (d_mem_req && !d_mem_ack) ? d_cnt + 1 : 0;
    if (rst_n && d_mem_req && d_mem_ack && d_mem_we) dmem[d_mem_addr[5:3]] <= d_mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    st_t s;
    if (rst_n && i_mem_req && i_mem_ack) begin
      if (exp_fetch.size() == 0) check("fetch_unexpected", {56'd0, i_mem_addr}, 64'hFFFF);
      else check("fetch_pc", {56'd0, i_mem_addr}, {56'd0, exp_fetch.pop_front()});
    end
    if (rst_n && d_mem_req && d_mem_ack) begin
      check("d_req_held", d_len + 1, d_wait + 1);
      if (d_mem_we) begin
        if (exp_st.size() == 0) check("store_unexpected", {58'd0, d_mem_addr}, 64'hFFFF);
        else begin
          s = exp_st.pop_front();
          check("store_addr", {58'd0, d_mem_addr}, {58'd0, s.addr});
          check("store_data", d_mem_wdata, s.data);
        end
      end
    end
    d_len <= (rst_n && d_mem_req && !d_mem_ack) ? d_len + 1 : 0;
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_sd(input int imm, input int rs2, input int rs1);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b011, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic clear_imem();
    for (int k = 0; k < 64; k++) imem[k] = 32'hFFFF_FFFF;
  endtask
  task automatic push_st(input logic [5:0] a, input logic [63:0] d);
    st_t s;
    s.addr = a; s.data = d;
    exp_st.push_back(s);
  endtask
  task automatic push_fetch(input logic [7:0] a);
    exp_fetch.push_back(a);
  endtask

  task automatic start_phase(input string tag, input int iw, input int dw);
    @(negedge clk);
    rst_n = 1'b0; i_wait = iw; d_wait = dw;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_reset_outs"}, {i_mem_req, d_mem_req, d_mem_we, retire, halt, i_mem_addr}, 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_retire(input string tag, input int exp_n);
    int n = 0;
    do begin @(negedge clk); n++; end while (!retire && n < 200);
    check(tag, n, exp_n);
  endtask

  task automatic wait_halt(input string tag, input int exp_rc, input int exp_lat);
    int n = 0, rc = 0, last = 0;
    while (!halt && n < 400) begin
      @(negedge clk); n++;
      if (retire) begin rc++; last = n; end
    end
    check({tag, "_halted"}, halt, 1);
    check({tag, "_retires"}, rc, exp_rc);
    check({tag, "_halt_lat"}, n - last, exp_lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check({tag, "_quiet"}, {i_mem_req, d_mem_req, retire, halt}, 4'b0001);
    end
    check({tag, "_fetch_q_empty"}, exp_fetch.size(), 0);
    check({tag, "_store_q_empty"}, exp_st.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 8; k++) dmem[k] = '0;

    // Phase 1: ALU ops, zero-wait memories, illegal word halts
    clear_imem();
    imem[0]  = enc_i(5, 0, 3'b000, 1, 7'b0010011);
    imem[1]  = enc_i(-3, 0, 3'b000, 2, 7'b0010011);
    imem[2]  = enc_r(7'h00, 2, 1, 3'b000, 3);
    imem[3]  = enc_sd(0, 3, 0);
    imem[4]  = enc_r(7'h20, 2, 1, 3'b000, 4);
    imem[5]  = enc_r(7'h00, 2, 1, 3'b111, 5);
    imem[6]  = enc_r(7'h00, 2, 1, 3'b110, 6);
    imem[7]  = enc_r(7'h00, 2, 1, 3'b100, 7);
    imem[8]  = enc_r(7'h00, 1, 2, 3'b010, 8);
    imem[9]  = enc_r(7'h00, 2, 1, 3'b010, 9);
    imem[10] = enc_r(7'h00, 1, 1, 3'b000, 0);
    imem[11] = enc_sd(8, 4, 0);
    imem[12] = enc_sd(16, 5, 0);
    imem[13] = enc_sd(24, 6, 0);
    imem[14] = enc_sd(32, 7, 0);
    imem[15] = enc_sd(40, 8, 0);
    imem[16] = enc_sd(48, 9, 0);
    imem[17] = enc_sd(56, 0, 0);
    for (int k = 0; k <= 18; k++) push_fetch(8'(4 * k));
    push_st(0, 64'd2);
    push_st(8, 64'd8);
    push_st(16, 64'd5);
    push_st(24, 64'hFFFF_FFFF_FFFF_FFFD);
    push_st(32, 64'hFFFF_FFFF_FFFF_FFF8);
    push_st(40, 64'd1);
    push_st(48, 64'd0);
    push_st(56, 64'd0);
    start_phase("p1", 0, 0);
    wait_retire("p1_retire1", 4);
    wait_retire("p1_retire2", 4);
    wait_retire("p1_retire3", 4);
    wait_halt("p1", 15, 3);

    // Phase 2: store then load with three data wait states
    clear_imem();
    imem[0] = enc_i(5, 0, 3'b000, 1, 7'b0010011);
    imem[1] = enc_sd(8, 1, 0);
    imem[2] = enc_i(8, 0, 3'b011, 4, 7'b0000011);
    imem[3] = enc_sd(16, 4, 0);
    for (int k = 0; k <= 4; k++) push_fetch(8'(4 * k));
    push_st(8, 64'd5);
    push_st(16, 64'd5);
    start_phase("p2", 0, 3);
    wait_retire("p2_addi_lat", 4);
    wait_retire("p2_sd_lat", 8);
    wait_retire("p2_ld_lat", 8);
    wait_retire("p2_sd2_lat", 8);
    wait_halt("p2", 0, 3);

    // Phase 3: branches and jal with one fetch wait state
    clear_imem();
    imem[0]  = enc_i(5, 0, 3'b000, 1, 7'b0010011);
    imem[1]  = enc_j(8, 0);
    imem[2]  = enc_j(24, 0);
    imem[3]  = enc_b(-4, 1, 1, 3'b000);
    imem[8]  = enc_j(16, 5);
    imem[12] = enc_b(8, 1, 1, 3'b001);
    imem[13] = enc_sd(0, 5, 0);
    push_fetch(0); push_fetch(4); push_fetch(12); push_fetch(8);
    push_fetch(8'h20); push_fetch(8'h30); push_fetch(8'h34); push_fetch(8'h38);
    push_st(0, 64'h24);
    start_phase("p3", 1, 0);
    wait_retire("p3_addi_lat", 5);
    wait_halt("p3", 6, 4);

    // Phase 4: reset during a pending fetch, late ack ignored, registers cleared
    clear_imem();
    imem[0] = enc_i(7, 1, 3'b000, 1, 7'b0010011);
    imem[1] = enc_i(1, 1, 3'b000, 1, 7'b0010011);
    imem[2] = enc_sd(0, 1, 0);
    push_fetch(0);
    start_phase("p4", 0, 0);
    wait_retire("p4_first_lat", 4);
    i_wait = 20;
    @(negedge clk);
    @(negedge clk);
    check("p4_fetch_pending", {i_mem_req, i_mem_addr}, {1'b1, 8'd4});
    rst_n = 1'b0;
    @(negedge clk);
    check("p4_reset_midfetch", {i_mem_req, d_mem_req, retire, halt, i_mem_addr}, 64'd0);
    push_fetch(0); push_fetch(4); push_fetch(8); push_fetch(12);
    push_st(0, 64'd8);
    rst_n = 1'b1;
    i_ack_force = 1'b1;
    @(posedge clk);
    #1;
    i_ack_force = 1'b0;
    i_wait = 0;
    @(negedge clk);
    check("p4_late_ack_ignored", {i_mem_req, i_mem_addr}, {1'b1, 8'd0});
    wait_retire("p4_restart_lat", 3);
    wait_halt("p4", 2, 3);

    // Phase 5: mul x6,x1,x2 with x1=7, x2=-3
    clear_imem();
    imem[0] = enc_i(7, 0, 3'b000, 1, 7'b0010011);
    imem[1] = enc_i(-3, 0, 3'b000, 2, 7'b0010011);
    imem[2] = enc_r(7'h01, 2, 1, 3'b000, 6);
    imem[3] = enc_sd(0, 6, 0);
`ifdef FD_MC_MUL_EN
    for (int k = 0; k <= 4; k++) push_fetch(8'(4 * k));
    push_st(0, 64'hFFFF_FFFF_FFFF_FFEB);
    start_phase("p5", 0, 0);
    wait_retire("p5_addi1_lat", 4);
    wait_retire("p5_addi2_lat", 4);
    wait_retire("p5_mul_lat", 67);
    wait_retire("p5_sd_lat", 5);
    wait_halt("p5", 0, 3);
`else
    for (int k = 0; k <= 2; k++) push_fetch(8'(4 * k));
    start_phase("p5", 0, 0);
    wait_retire("p5_addi1_lat", 4);
    wait_retire("p5_addi2_lat", 4);
    wait_halt("p5_mul_illegal", 0, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fd_multiciclo.md
Name: fd_multiciclo

Overview:
- Parametrised multi-cycle successor to the single-cycle RV64 datapath.
- Integrates PC, IR, A/B/MDR/ALUOut latches, a 32-entry register file, the ALU and an internal stage sequencer.
- Executes a RISC-V integer subset over handshaked instruction and data memories that may insert wait states.
- Sits between the program memory and the data memory; needs no external control unit.

Parameters:
- xlen, 64, datapath/register width; legal values 32 or 64.
- i_addr_w, 6, instruction memory byte-address width; i_mem_addr = pc[i_addr_w-1:0].
- d_addr_w, 6, data memory byte-address width; d_mem_addr = ALUOut[d_addr_w-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_mem_addr  out  i_addr_w  fetch address (PC).
- i_mem_req  out  1  fetch request, held until acknowledged.
- i_mem_ack  in  1  fetch done; i_mem_data valid this cycle.
- i_mem_data  in  32  instruction word.
- d_mem_addr  out  d_addr_w  load/store address.
- d_mem_req  out  1  data access request.
- d_mem_we  out  1  1 = store, 0 = load; valid while d_mem_req=1.
- d_mem_wdata  out  xlen  store data (rs2 value).
- d_mem_rdata  in  xlen  load data, valid with d_mem_ack.
- d_mem_ack  in  1  data access done.
- retire  out  1  one-cycle pulse per completed instruction.
- halt  out  1  sticky; core stopped on an illegal instruction.

Behaviour:
- Reset: rst_n sampled low at a rising edge gives:
  - pc=0, all 32 registers=0, state=FETCH.
  - i_mem_req=0, d_mem_req=0, d_mem_we=0, retire=0, halt=0.
  - This applies in any state, including mid-handshake. The in-flight access is abandoned and a late ack is ignored.
  - The first request rises in the cycle after rst_n returns high.
- An ack counts only in a cycle where the matching req=1. An ack with req=0 is ignored.
- FETCH:
  - Assert i_mem_req, which stays high each cycle until i_mem_ack=1.
  - On ack, IR<=i_mem_data, then go to DECODE.
- DECODE:
  - A<=x[rs1], B<=x[rs2], imm<=sign-extended immediate per format (I, S, B, J).
  - Unsupported opcode/funct → HALT.
  - Otherwise → EXEC.
- EXEC: ALUOut computed.
  - Loads/stores → MEM; all other instructions → WB.
- MEM:
  - d_mem_req=1, d_mem_we=1 for stores. Held until d_mem_ack.
  - On ack, loads latch MDR<=d_mem_rdata. Then → WB.
- WB:
  - Write rd (writes to x0 discarded; x0 always reads 0).
  - pc updated; retire=1 for exactly this cycle.
  - → FETCH.
- HALT: all requests 0, halt=1, held until reset.
- Supported instructions:
  - R-type: add, sub, and, or, xor, slt (signed).
  - I-type: addi.
  - Load/store: ld/sd when xlen=64 (funct3=011); lw/sw when xlen=32 (funct3=010).
  - Branches: beq, bne.
  - jal.
- Arithmetic: modulo 2^xlen, overflow ignored. slt result is 0 or 1.
- PC update:
  - Default pc+4.
  - Taken branch or jal: pc+imm.
  - jal writes pc+4 (the old pc) to rd.
  - PC wraps modulo 2^xlen.
- Latency with zero-wait memory (ack in the same cycle as req):
  - R/I/branch/jal: 4 cycles.
  - Load/store: 5 cycles.
  - Each wait cycle on either memory adds 1 cycle.
- Registers updated only in the documented states; outputs driven from state/latches, not from memory inputs.

Optional Feature:
- FD_MC_MUL_EN defined:
  - Adds mul (opcode 0110011, funct7=0000001, funct3=000): low xlen bits of rs1*rs2.
  - Computed by an iterative shift-add unit, one bit per cycle, that stays in EXEC for xlen cycles.
  - Total mul latency with zero-wait memory: xlen+3 cycles.
  - Reset during the multiply abandons it.
- FD_MC_MUL_EN undefined: that encoding is illegal → HALT.

Test Plan:
- Reset, then program `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2` with zero-wait memory → x3=2; retire pulses at cycles 4, 8, 12 after reset release.
- `sd x1,8(x0)` then `ld x4,8(x0)` with d_mem_ack delayed 3 cycles → stored word 5 at address 8; x4=5; each access takes 8 cycles; d_mem_req held high through the wait.
- `beq x1,x1,-4` → pc goes back 4; `bne x1,x1,+8` → pc+4; `jal x5,+16` from pc=0x20 → pc=0x30, x5=0x24.
- Assert rst_n=0 while i_mem_req is high in FETCH and the ack is pending → next cycle pc=0, i_mem_req=0; a late ack is ignored; execution restarts cleanly at 0.
- Illegal word 0xFFFFFFFF → halt=1 after DECODE; no further requests; retire stays 0 until reset.
- FD_MC_MUL_EN, xlen=64: `mul x6,x1,x2` with x1=7, x2=-3 → x6=-21 (0xFFFF_FFFF_FFFF_FFEB) after 67 cycles; without the macro → halt=1.
